// File: rtl/program_loader_4bit.sv
// Buffers a header/instruction/data byte stream, then replays it onto the computer_4bit load bus under reset.
// Latency: first slot one cycle after the last accepted byte; cpu_rst released HOLD_CYCLES after the last slot.
// Backpressure: byte_ready is high only while receiving and reload is low. Optional checksum: LOADER_CHECKSUM_EN.
module program_loader_4bit #(
    parameter logic [7:0]  PAD_INS     = 8'h0F,
    parameter logic [3:0]  PAD_DATA    = 4'h0,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       reload,
    output logic       cpu_rst,
    output logic [3:0] cpu_ins_address,
    output logic [7:0] cpu_ins,
    output logic [3:0] cpu_d_in,
    output logic       loading,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_INS,
        S_RX_DATA,
        S_DRIVE,
        S_HOLD,
        S_RUN
`ifdef LOADER_CHECKSUM_EN
        , S_RX_CSUM
        , S_ERR
`endif
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] n_q, n_d;          // instruction count minus one
    logic [3:0] m_q, m_d;          // data count minus one
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] slot_q, slot_d;
    logic [3:0] hold_q, hold_d;
    logic       cpu_rst_d, loading_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] ins_q, ins_d;
    logic [3:0] din_q, din_d;
    logic [3:0] last_slot;
    logic       accept, ins_we, data_we;

    logic [7:0] ins_store  [16];
    logic [3:0] data_store [16];

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic [7:0] csum_fin;
    logic       err_q, err_d;
    assign csum_fin = csum_q + byte_in;
    assign err      = err_q;
    assign byte_ready = !reload && (state_q == S_IDLE || state_q == S_RX_INS ||
                                    state_q == S_RX_DATA || state_q == S_RX_CSUM);
`else
    assign err        = 1'b0;
    assign byte_ready = !reload && (state_q == S_IDLE || state_q == S_RX_INS ||
                                    state_q == S_RX_DATA);
`endif

    assign accept    = byte_valid && byte_ready;
    assign ins_we    = accept && !rst && (state_q == S_RX_INS);
    assign data_we   = accept && !rst && (state_q == S_RX_DATA);
    assign last_slot = (n_q > m_q) ? n_q : m_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        hold_d  = hold_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (reload) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    n_d     = byte_in[3:0];
                    m_d     = byte_in[7:4];
                    cnt_d   = 4'd0;
                    state_d = S_RX_INS;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = byte_in;
`endif
                end
                S_RX_INS: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_fin;
`endif
                    if (cnt_q == n_q) begin
                        cnt_d   = 4'd0;
                        state_d = S_RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                S_RX_DATA: if (accept) begin
                    if (cnt_q == m_q) begin
                        slot_d  = 4'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = csum_fin;
                        state_d = S_RX_CSUM;
`else
                        state_d = S_DRIVE;
`endif
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_fin;
`endif
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_RX_CSUM: if (accept) begin
                    slot_d  = 4'd0;
                    state_d = (csum_fin == 8'd0) ? S_DRIVE : S_ERR;
                end
`endif
                S_DRIVE: begin
                    if (slot_q == last_slot) begin
                        hold_d  = 4'd0;
                        state_d = S_HOLD;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) state_d = S_RUN;
                    else                     hold_d  = hold_q + 4'd1;
                end
                default: state_d = state_q;
            endcase
        end

        // Outputs are registered, so they are derived from the state being entered.
        cpu_rst_d = (state_d != S_RUN);
        loading_d = (state_d == S_RX_INS) || (state_d == S_RX_DATA) ||
                    (state_d == S_DRIVE)  || (state_d == S_HOLD);
`ifdef LOADER_CHECKSUM_EN
        loading_d = loading_d || (state_d == S_RX_CSUM);
        err_d     = (state_d == S_ERR);
`endif
        addr_d = 4'd0;
        ins_d  = 8'd0;
        din_d  = 4'd0;
        if (state_d == S_DRIVE) begin
            addr_d = slot_d;
            ins_d  = (slot_d <= n_q) ? ins_store[slot_d] : PAD_INS;
            // Slot 0 can coincide with the final data write when M=1.
            if (slot_d <= m_q)
                din_d = (data_we && cnt_q == slot_d) ? byte_in[3:0] : data_store[slot_d];
            else
                din_d = PAD_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= 4'd0;
            m_q     <= 4'd0;
            cnt_q   <= 4'd0;
            slot_q  <= 4'd0;
            hold_q  <= 4'd0;
            cpu_rst <= 1'b1;
            loading <= 1'b0;
            addr_q  <= 4'd0;
            ins_q   <= 8'd0;
            din_q   <= 4'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            hold_q  <= hold_d;
            cpu_rst <= cpu_rst_d;
            loading <= loading_d;
            addr_q  <= addr_d;
            ins_q   <= ins_d;
            din_q   <= din_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (ins_we)  ins_store[cnt_q]  <= byte_in;
        if (data_we) data_store[cnt_q] <= byte_in[3:0];
    end

    assign cpu_ins_address = addr_q;
    assign cpu_ins         = ins_q;
    assign cpu_d_in        = din_q;

endmodule

// File: tb/tb_program_loader_4bit.sv
// Bench for program_loader_4bit: directed and random images against a slot-list model.
// Latency: n/a. Backpressure: random byte_valid gaps; reload/rst mid-stream.
module tb_program_loader_4bit;

    typedef logic [7:0] bq_t [$];

    localparam int HOLD = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       reload = 1'b0;
    logic       cpu_rst;
    logic [3:0] cpu_ins_address;
    logic [7:0] cpu_ins;
    logic [3:0] cpu_d_in;
    logic       loading;
    logic       err;

    int tests = 0;
    int failures = 0;

    program_loader_4bit #(.PAD_INS(8'h0F), .PAD_DATA(4'h0), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .reload(reload), .cpu_rst(cpu_rst),
        .cpu_ins_address(cpu_ins_address), .cpu_ins(cpu_ins), .cpu_d_in(cpu_d_in),
        .loading(loading), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc = 1'b0;
        int budget = 0;
        int k = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && k < 8) begin
                @(negedge clk);
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                k++;
            end
        end
        while (!acc && budget < 100) begin
            @(negedge clk);
            byte_in    = b;
            byte_valid = 1'b1;
            #1;
            acc = byte_ready;
            @(posedge clk);
            budget++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic stream_image(input logic [7:0] hdr, input bq_t ins, input bq_t dat,
                                input bit gaps, input logic [7:0] csum_adj);
        logic [7:0] sum;
        sum = hdr;
        send_byte(hdr, gaps);
        foreach (ins[i]) begin
            send_byte(ins[i], gaps);
            sum = sum + ins[i];
        end
        foreach (dat[i]) begin
            send_byte(dat[i], gaps);
            sum = sum + dat[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'(8'd0 - sum) + csum_adj, gaps);
`else
        if (csum_adj != 8'd0 && sum == 8'd0) $display("note: checksum adjust unused");
`endif
    endtask

    // Model: slot j shows ins[j] or HLT pad, data[j][3:0] or zero pad; S = max(N,M).
    task automatic check_replay(input string tag, input logic [7:0] hdr, input bq_t ins, input bq_t dat);
        int n, m, s;
        logic [7:0] e_ins;
        logic [3:0] e_din;
        n = int'(hdr[3:0]) + 1;
        m = int'(hdr[7:4]) + 1;
        s = (n > m) ? n : m;
        for (int j = 0; j < s; j++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            #1;
            e_ins = (j < n) ? ins[j] : 8'h0F;
            if (j < m) begin
                e_din = dat[j][3:0];
            end else begin
                e_din = 4'h0;
            end
            chk({tag, "_addr"},  32'(cpu_ins_address), 32'(j));
            chk({tag, "_ins"},   32'(cpu_ins), 32'(e_ins));
            chk({tag, "_din"},   32'(cpu_d_in), 32'(e_din));
            chk({tag, "_rst"},   32'(cpu_rst), 32'd1);
            chk({tag, "_load"},  32'(loading), 32'd1);
            chk({tag, "_rdy"},   32'(byte_ready), 32'd0);
        end
        for (int h = 0; h < HOLD; h++) begin
            @(negedge clk);
            #1;
            chk({tag, "_hold_rst"},  32'(cpu_rst), 32'd1);
            chk({tag, "_hold_bus"},  {20'd0, cpu_ins_address, cpu_ins}, 32'd0);
            chk({tag, "_hold_din"},  32'(cpu_d_in), 32'd0);
        end
        @(negedge clk);
        #1;
        chk({tag, "_run_rst"},  32'(cpu_rst), 32'd0);
        chk({tag, "_run_load"}, 32'(loading), 32'd0);
        chk({tag, "_run_bus"},  {20'd0, cpu_ins_address, cpu_ins}, 32'd0);
        chk({tag, "_run_err"},  32'(err), 32'd0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        byte_valid = 1'b0;
        reload     = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        #1;
        chk("reload_rdy", 32'(byte_ready), 32'd1);
        chk("reload_rst", 32'(cpu_rst), 32'd1);
    endtask

    initial begin
        bq_t img1_ins, img1_dat, i2_ins, i2_dat, r_ins, r_dat;
        logic [7:0] hdr;
        img1_ins = '{8'h16, 8'h02, 8'h77, 8'h00, 8'h04, 8'h0F};
        img1_dat = '{8'h00, 8'h05};
        i2_ins   = '{8'h12};
        i2_dat   = '{8'h01, 8'h02, 8'h03, 8'h04};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_bus", {20'd0, cpu_ins_address, cpu_ins}, 32'd0);
        chk("rst_din", 32'(cpu_d_in), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdy", 32'(byte_ready), 32'd1);

        // Image 1, no gaps
        stream_image(8'h15, img1_ins, img1_dat, 1'b0, 8'd0);
        check_replay("img1", 8'h15, img1_ins, img1_dat);

        // Image 2: N=1, M=4 padding
        do_reload();
        stream_image(8'h30, i2_ins, i2_dat, 1'b0, 8'd0);
        check_replay("img2", 8'h30, i2_ins, i2_dat);

        // Image 1 with random valid gaps
        do_reload();
        stream_image(8'h15, img1_ins, img1_dat, 1'b1, 8'd0);
        check_replay("img1_gap", 8'h15, img1_ins, img1_dat);

        // Reload mid-stream, coincident with a valid byte
        do_reload();
        send_byte(8'h15, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h77, 1'b0);
        @(negedge clk);
        byte_in    = 8'hAA;
        byte_valid = 1'b1;
        reload     = 1'b1;
        #1;
        chk("reload_blocks_rdy", 32'(byte_ready), 32'd0);
        @(negedge clk);
        reload     = 1'b0;
        byte_valid = 1'b0;
        #1;
        chk("reload_loading", 32'(loading), 32'd0);
        chk("reload_idle_rdy", 32'(byte_ready), 32'd1);
        stream_image(8'h15, img1_ins, img1_dat, 1'b0, 8'd0);
        check_replay("img1_after_reload", 8'h15, img1_ins, img1_dat);

        // rst while in RUN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("run_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("run_rst_bus", {20'd0, cpu_ins_address, cpu_ins}, 32'd0);
        chk("run_rst_rdy", 32'(byte_ready), 32'd1);

        // Boundary images then random images with gaps
        for (int t = 0; t < 7; t++) begin
            case (t)
                0:       hdr = 8'h00;
                1:       hdr = 8'hFF;
                2:       hdr = 8'h0F;
                3:       hdr = 8'hF0;
                default: hdr = 8'($urandom);
            endcase
            r_ins = {};
            r_dat = {};
            for (int i = 0; i <= int'(hdr[3:0]); i++) r_ins.push_back(8'($urandom));
            for (int i = 0; i <= int'(hdr[7:4]); i++) r_dat.push_back(8'($urandom));
            if (t != 0) do_reload();
            stream_image(hdr, r_ins, r_dat, t >= 4, 8'd0);
            check_replay($sformatf("rand%0d", t), hdr, r_ins, r_dat);
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: ERR, no slots, reload clears err
        do_reload();
        stream_image(8'h15, img1_ins, img1_dat, 1'b0, 8'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            #1;
            chk("csum_err", 32'(err), 32'd1);
            chk("csum_err_rst", 32'(cpu_rst), 32'd1);
            chk("csum_err_bus", {20'd0, cpu_ins_address, cpu_ins}, 32'd0);
            chk("csum_err_rdy", 32'(byte_ready), 32'd0);
        end
        do_reload();
        chk("csum_err_cleared", 32'(err), 32'd0);
        stream_image(8'h15, img1_ins, img1_dat, 1'b0, 8'd0);
        check_replay("csum_ok", 8'h15, img1_ins, img1_dat);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
